// File: rtl/const_mult_seq.sv
// Multiply-by-constant controller: walks the set bits of C one per cycle,
// accumulating shifted copies of the operand, with valid/ready on both sides.
module const_mult_seq #(
  parameter int unsigned W   = 32,
  parameter int unsigned C   = 21,
  parameter int unsigned CW  = $clog2(C + 1),
  parameter int unsigned Y_W = W + CW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [W-1:0]   in_a,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [Y_W-1:0] out_y,
  output logic           busy
);

  // C == 0 gives CW == 0; keep the mask at least one bit wide.
  localparam int unsigned MW = (CW > 0) ? CW : 1;
  localparam int unsigned IW = (MW > 1) ? $clog2(MW) : 1;
  localparam logic [MW-1:0] C_MASK = MW'(C);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   a_r;
  logic [Y_W-1:0] acc;
  logic [MW-1:0]  mask;
  logic [MW-1:0]  mask_clr;
  logic [IW-1:0]  low_idx;
  logic           low_found;
  logic [Y_W-1:0] addend;
  logic           accept;

  assign accept = in_vld & in_rdy;

  // Index of the lowest remaining set bit of the constant.
  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    for (int i = 0; i < int'(MW); i++) begin
      if (mask[i] && !low_found) begin
        low_idx   = IW'(i);
        low_found = 1'b1;
      end
    end
  end

  assign mask_clr = mask & (mask - MW'(1));
  assign addend   = low_found ? (Y_W'(a_r) << low_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ACCUM;
      ACCUM:   if (mask_clr == '0) state_nxt = DONE;
      DONE:    if (out_rdy) state_nxt = accept ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, independent of the clock.
  always_comb begin
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    busy    = 1'b0;
    out_y   = '0;
    if (rst_n) begin
      out_y = acc;
      unique case (state)
        IDLE:  in_rdy = 1'b1;
        ACCUM: busy = 1'b1;
        DONE: begin
          busy    = 1'b1;
          out_vld = 1'b1;
          in_rdy  = out_rdy;
        end
        default: ;
      endcase
    end
  end

  // The running sum never exceeds a*C, so acc cannot overflow Y_W bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r  <= '0;
      acc  <= '0;
      mask <= '0;
    end else if (accept) begin
      a_r  <= in_a;
      acc  <= '0;
      mask <= C_MASK;
    end else if (state == ACCUM) begin
      acc  <= acc + addend;
      mask <= mask_clr;
    end
  end

endmodule
